tmds_encoder_x3: RTL
====================

# tmds_encoder_x3

- Three-channel TMDS 8b/10b encoder for the HDMI TX datapath.
- Takes 24-bit RGB pixels plus DE/HSYNC/VSYNC in the pixel clock domain.
- Produces a 40-bit symbol word each cycle: three DC-balanced 10-bit data channels plus the fixed 10-bit clock-channel pattern.
- Sits directly upstream of the 40-bit symbol delay line, which feeds the serializers.

## Interface
- No parameters.
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- de  in  1  video data enable; 1 = active pixel, 0 = control period
- hsync  in  1  horizontal sync, sampled with pixel
- vsync  in  1  vertical sync, sampled with pixel
- pix_r  in  8  red component
- pix_g  in  8  green component
- pix_b  in  8  blue component
- data_o  out  40  encoded symbols:
  - [9:0] ch0 (blue)
  - [19:10] ch1 (green)
  - [29:20] ch2 (red)
  - [39:30] clock channel

## Operation
- One symbol word is accepted every cycle; there is no stall or handshake.
- Stage 1 (per data channel), transition minimisation:
  - N1(D) = popcount of the 8-bit input.
  - If N1(D) > 4, or N1(D) == 4 with D[0] == 0: q_m[i] = ~(q_m[i-1] ^ D[i]) and q_m[8] = 0.
  - Otherwise: q_m[i] = q_m[i-1] ^ D[i] and q_m[8] = 1.
  - In both cases q_m[0] = D[0].
  - Registered with N1(q_m[7:0]), de, hsync and vsync.
- Stage 2 (per data channel), DC balance:
  - cnt is a 5-bit signed running disparity held per channel; N0 = 8 − N1(q_m[7:0]).
  - If cnt == 0 or N1 == N0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - cnt += q_m[8] ? (N1 − N0) : (N0 − N1)
  - Else if (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1):
    - out = {1, q_m[8], ~q_m[7:0]}
    - cnt += 2·q_m[8] + (N0 − N1)
  - Else:
    - out = {0, q_m[8], q_m[7:0]}
    - cnt += −2·(~q_m[8]) + (N1 − N0)
- Control period (stage-2 de == 0):
  - Control code {c1,c0}, written bit9..bit0:
    - 00 → 10'b1101010100
    - 01 → 10'b0010101011
    - 10 → 10'b0101010100
    - 11 → 10'b1010101011
  - ch0 uses {c1,c0} = {vsync, hsync}; ch1 and ch2 use 00.
  - cnt of all channels is forced to 0.
- Clock channel [39:30] is constant 10'b0000011111 whenever not in reset.
- Arithmetic: popcounts are 4-bit unsigned, zero-extended to 5-bit signed before any add. cnt stays within −10..+10 and never wraps.

## Timing
- Latency: 2 cycles from input sample to data_o (3 with TMDS_INPUT_REG_EN).
- Throughput: 1 symbol word per cycle.
- DE transitions take effect on exactly the pixel sampled with the new DE value; there is no blending across the boundary.
- Reset (sync, active-high): data_o = 40'b0, all cnt = 0, all pipeline registers = 0.
- First valid word appears 2 cycles after reset deasserts.
- Reset asserted mid-line: the next edge clears everything; in-flight pixels are discarded, not flushed.
- Reset wins over all other inputs on the same edge.

## Configuration
- TMDS_INPUT_REG_EN:
  - Defined: adds a register stage on de, hsync, vsync and pix_* ahead of stage 1. Latency 3; the register resets to 0.
  - Undefined: inputs go straight into stage 1. Latency 2.
- Encoding results are identical either way; only latency differs.

## Test plan
- Reset, then de=0, hsync=1, vsync=0 held for 4 cycles → from cycle 2 after reset deassert, data_o = {10'h01F, 10'h354, 10'h354, 10'h0AB}.
- de=1, all pix = 8'h00 for 3 consecutive cycles after a control period → each channel outputs 10'h100, 10'h3FF, 10'h100; cnt goes −8, +2, −6.
- de=1, pix_b = 8'hFF, pix_g = 8'h55 → decode each output symbol with a reference decoder and check it recovers the input byte. Over 1000 random pixels, |cnt| ≤ 10 at every cycle.
- de 1→0 with cnt ≠ 0, then 0→1 → cnt reads 0 on the first active pixel, whose encoding matches the cnt == 0 rule.
- Reset pulsed for 1 cycle mid-active-line → data_o = 0 on the next cycle. The pixel presented at deassert appears at latency 2, encoded with cnt = 0.
- Rebuild with TMDS_INPUT_REG_EN and rerun the first test → the same codes appear one cycle later.

Source files
------------

// File: rtl/tmds_encoder_x3.sv
// Three-channel TMDS 8b/10b encoder with a fixed clock-channel pattern.
// Stage 1: transition minimisation. Stage 2: DC balance or control codes.
// Optional macro TMDS_INPUT_REG_EN adds an input register (latency 3 instead of 2).
module tmds_encoder_x3 (
  input  logic        clk,
  input  logic        reset,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic [39:0] data_o
);

  localparam logic [9:0] CLK_PATTERN = 10'b0000011111;
  localparam logic [9:0] CTRL_00     = 10'b1101010100;
  localparam logic [9:0] CTRL_01     = 10'b0010101011;
  localparam logic [9:0] CTRL_10     = 10'b0101010100;
  localparam logic [9:0] CTRL_11     = 10'b1010101011;

  // Stage-1 input view; channel 0 = blue, 1 = green, 2 = red
  logic       s0_de, s0_hs, s0_vs;
  logic [7:0] s0_pix [3];

`ifdef TMDS_INPUT_REG_EN
  logic       in_de_q, in_hs_q, in_vs_q;
  logic [7:0] in_pix_q [3];

  // Optional input register ahead of stage 1
  always_ff @(posedge clk) begin
    if (reset) begin
      in_de_q <= 1'b0;
      in_hs_q <= 1'b0;
      in_vs_q <= 1'b0;
      for (int unsigned ch = 0; ch < 3; ch++) in_pix_q[ch] <= '0;
    end else begin
      in_de_q     <= de;
      in_hs_q     <= hsync;
      in_vs_q     <= vsync;
      in_pix_q[0] <= pix_b;
      in_pix_q[1] <= pix_g;
      in_pix_q[2] <= pix_r;
    end
  end

  // Stage 1 is fed from the input register
  always_comb begin
    s0_de = in_de_q;
    s0_hs = in_hs_q;
    s0_vs = in_vs_q;
    for (int unsigned ch = 0; ch < 3; ch++) s0_pix[ch] = in_pix_q[ch];
  end
`else
  // Stage 1 is fed straight from the ports
  always_comb begin
    s0_de     = de;
    s0_hs     = hsync;
    s0_vs     = vsync;
    s0_pix[0] = pix_b;
    s0_pix[1] = pix_g;
    s0_pix[2] = pix_r;
  end
`endif

  function automatic logic [3:0] popcnt8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  function automatic logic [8:0] tm_encode(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = popcnt8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int unsigned i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Returns {next cnt, symbol}; intermediate sums may wrap but the result stays in -10..+10
  function automatic logic [14:0] dc_balance(input logic [8:0] qm, input logic [3:0] n1,
                                             input logic signed [4:0] cnt);
    logic signed [4:0] n1s, n0s, diff, cnt_n;
    logic [9:0]        sym;
    n1s  = $signed({1'b0, n1});
    n0s  = 5'sd8 - n1s;
    diff = n1s - n0s;
    if ((cnt == 5'sd0) || (n1s == n0s)) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (n1s > n0s)) || ((cnt < 5'sd0) && (n0s > n1s))) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt - (qm[8] ? 5'sd0 : 5'sd2) + diff;
    end
    return {cnt_n, sym};
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  logic [8:0] qm_d [3];
  logic [8:0] qm_q [3];
  logic [3:0] n1_d [3];
  logic [3:0] n1_q [3];
  logic       de_q, hs_q, vs_q;

  // Stage 1 combinational: transition-minimised word and its popcount
  always_comb begin
    for (int unsigned ch = 0; ch < 3; ch++) begin
      qm_d[ch] = tm_encode(s0_pix[ch]);
      n1_d[ch] = popcnt8(qm_d[ch][7:0]);
    end
  end

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (reset) begin
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      for (int unsigned ch = 0; ch < 3; ch++) begin
        qm_q[ch] <= '0;
        n1_q[ch] <= '0;
      end
    end else begin
      de_q <= s0_de;
      hs_q <= s0_hs;
      vs_q <= s0_vs;
      for (int unsigned ch = 0; ch < 3; ch++) begin
        qm_q[ch] <= qm_d[ch];
        n1_q[ch] <= n1_d[ch];
      end
    end
  end

  logic signed [4:0] cnt_q [3];
  logic signed [4:0] cnt_d [3];
  logic [9:0]        sym_d [3];
  logic [39:0]       data_d, data_q;

  // Stage 2 combinational: DC balance in active video, control codes otherwise
  always_comb begin
    for (int unsigned ch = 0; ch < 3; ch++) begin
      {cnt_d[ch], sym_d[ch]} = dc_balance(qm_q[ch], n1_q[ch], cnt_q[ch]);
    end
    if (!de_q) begin
      for (int unsigned ch = 0; ch < 3; ch++) cnt_d[ch] = '0;
      sym_d[0] = ctrl_code({vs_q, hs_q});
      sym_d[1] = CTRL_00;
      sym_d[2] = CTRL_00;
    end
    data_d = {CLK_PATTERN, sym_d[2], sym_d[1], sym_d[0]};
  end

  // Stage 2 register: output word and running disparity
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      for (int unsigned ch = 0; ch < 3; ch++) cnt_q[ch] <= '0;
    end else begin
      data_q <= data_d;
      for (int unsigned ch = 0; ch < 3; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  assign data_o = data_q;

endmodule
